usb_rx_pkt_fifo: RTL and testbench

USB_RX_PKT_FIFO -- requirements
Module: usb_rx_pkt_fifo

---
 rtl/usb_rx_pkt_fifo.sv | 206 ++++++++++++++++++++
 tb/tb_usb_rx_pkt_fifo.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_pkt_fifo.sv
// USB OUT-endpoint receive packet FIFO.
// Stores good packets in a byte buffer; streams them out whole.
module usb_rx_pkt_fifo #(
    parameter int AW      = 11,
    parameter int MAX_PKT = 512,
    parameter int ENDPT   = 1,
    parameter int LQ_AW   = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [7:0]       rxdat_i,
    input  logic             rxval_i,
    input  logic             rxact_i,
    input  logic             rxpktval_i,
    input  logic             setup_i,
    input  logic [3:0]       endpt_i,
    output logic             rxrdy_o,
    output logic [7:0]       m_dat_o,
    output logic             m_val_o,
    output logic             m_last_o,
    input  logic             m_rdy_i,
    output logic [LQ_AW:0]   pkt_cnt_o,
    output logic [7:0]       drop_cnt_o
);

    localparam int DEPTH = 1 << AW;
    localparam int LQ_D  = 1 << LQ_AW;
    localparam logic [AW:0] DEPTH_W = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] MAX_W = (AW+1)'(MAX_PKT);
    localparam logic [AW:0] ONE_W = (AW+1)'(1);
    localparam logic [LQ_AW:0] LQ_FULL = {1'b1, {LQ_AW{1'b0}}};
    localparam logic [LQ_AW:0] LQ_ONE = (LQ_AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DROP,
        FLUSH
    } state_t;

    state_t state, state_n;

    logic [7:0]    mem [DEPTH];
    logic [AW:0]   lq_mem [LQ_D];

    logic [AW:0]    wr_ptr, cwr_ptr, rd_ptr, fetch_ptr;
    logic [AW:0]    byte_cnt, cnt_n;
    logic           good, good_n;
    logic [LQ_AW:0] lq_wp, lq_rp, lq_fp;
    logic [AW:0]    fetch_rem;
    logic [7:0]     ram_q;
    logic           s1_val, s1_last;

    logic wr_en, commit, rollback, drop_inc;
    logic buf_full;
    logic s2_free, s1_move, fetch, last_xfer;
    logic [AW:0] cur_len, head_len;
    logic [AW:0] cwr_n, rd_n, free_n;
    logic [LQ_AW:0] pcnt_n;

    assign buf_full = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign last_xfer = m_val_o & m_rdy_i & m_last_o;
    assign s2_free   = ~m_val_o | m_rdy_i;
    assign s1_move   = s1_val & s2_free;
    assign cur_len   = (fetch_rem != '0) ? fetch_rem
                                         : lq_mem[lq_fp[LQ_AW-1:0]];
    assign fetch     = ((fetch_rem != '0) | (lq_wp != lq_fp)) &
                       (~s1_val | s1_move);
    assign head_len  = lq_mem[lq_rp[LQ_AW-1:0]];
    assign pkt_cnt_o = lq_wp - lq_rp;

    // Write FSM state register
    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_n;
    end

    // Write FSM next-state and control decode
    always_comb begin
        state_n  = state;
        cnt_n    = byte_cnt;
        good_n   = good;
        wr_en    = 1'b0;
        commit   = 1'b0;
        rollback = 1'b0;
        drop_inc = 1'b0;
        unique case (state)
            IDLE: begin
                good_n = 1'b0;
                cnt_n  = '0;
                if (rxact_i) begin
                    if (endpt_i == 4'(ENDPT) && !setup_i) state_n = RECV;
                    else                                  state_n = FLUSH;
                end
            end
            RECV: begin
                if (rxpktval_i) good_n = 1'b1;
                if (!rxact_i) begin
                    state_n = IDLE;
                    if (good || rxpktval_i) begin
                        if (byte_cnt != '0) commit = 1'b1;
                    end else begin
                        rollback = 1'b1;
                        drop_inc = 1'b1;
                    end
                end else if (rxval_i) begin
                    if (buf_full || byte_cnt >= MAX_W) begin
                        state_n = DROP;
                    end else begin
                        wr_en = 1'b1;
                        cnt_n = byte_cnt + ONE_W;
                    end
                end
            end
            DROP: begin
                if (!rxact_i) begin
                    state_n  = IDLE;
                    rollback = 1'b1;
                    drop_inc = 1'b1;
                end
            end
            FLUSH: begin
                if (!rxact_i) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Post-edge pointer values used to register rxrdy_o
    always_comb begin
        cwr_n  = commit ? cwr_ptr + byte_cnt : cwr_ptr;
        rd_n   = last_xfer ? rd_ptr + head_len : rd_ptr;
        pcnt_n = (commit ? lq_wp + LQ_ONE : lq_wp) -
                 (last_xfer ? lq_rp + LQ_ONE : lq_rp);
        free_n = DEPTH_W - (cwr_n - rd_n);
    end

    // Byte buffer write port
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= rxdat_i;
    end

    // Byte buffer synchronous read port
    always_ff @(posedge clk_i) begin
        if (fetch) ram_q <= mem[fetch_ptr[AW-1:0]];
    end

    // Pointers, length queue, counters and output pipeline
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr     <= '0;
            cwr_ptr    <= '0;
            rd_ptr     <= '0;
            fetch_ptr  <= '0;
            byte_cnt   <= '0;
            good       <= 1'b0;
            lq_wp      <= '0;
            lq_rp      <= '0;
            lq_fp      <= '0;
            fetch_rem  <= '0;
            s1_val     <= 1'b0;
            s1_last    <= 1'b0;
            m_val_o    <= 1'b0;
            m_last_o   <= 1'b0;
            m_dat_o    <= '0;
            rxrdy_o    <= 1'b0;
            drop_cnt_o <= '0;
            for (int i = 0; i < LQ_D; i++) lq_mem[i] <= '0;
        end else begin
            byte_cnt <= cnt_n;
            good     <= good_n;
            if (wr_en)         wr_ptr <= wr_ptr + ONE_W;
            else if (rollback) wr_ptr <= cwr_ptr;
            if (commit) begin
                cwr_ptr <= cwr_ptr + byte_cnt;
                lq_mem[lq_wp[LQ_AW-1:0]] <= byte_cnt;
                lq_wp <= lq_wp + LQ_ONE;
            end
            if (drop_inc && drop_cnt_o != 8'hff)
                drop_cnt_o <= drop_cnt_o + 8'd1;
            if (last_xfer) begin
                rd_ptr <= rd_ptr + head_len;
                lq_rp  <= lq_rp + LQ_ONE;
            end
            if (fetch) begin
                fetch_ptr <= fetch_ptr + ONE_W;
                fetch_rem <= cur_len - ONE_W;
                s1_last   <= (cur_len == ONE_W);
                if (fetch_rem == '0) lq_fp <= lq_fp + LQ_ONE;
            end
            s1_val <= fetch | (s1_val & ~s1_move);
            if (s2_free) begin
                m_val_o <= s1_val;
                if (s1_val) begin
                    m_dat_o  <= ram_q;
                    m_last_o <= s1_last;
                end
            end
            rxrdy_o <= (state_n == IDLE) && (free_n >= MAX_W) &&
                       (pcnt_n != LQ_FULL);
        end
    end

endmodule

// File: tb/tb_usb_rx_pkt_fifo.sv
// Randomized self-checking bench for usb_rx_pkt_fifo.
// A packet-level model predicts the output stream and counters.
module tb_usb_rx_pkt_fifo;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] rxdat_i = '0;
    logic       rxval_i = 1'b0;
    logic       rxact_i = 1'b0;
    logic       rxpktval_i = 1'b0;
    logic       setup_i = 1'b0;
    logic [3:0] endpt_i = '0;
    logic       rxrdy_o;
    logic [7:0] m_dat_o;
    logic       m_val_o;
    logic       m_last_o;
    logic       m_rdy_i = 1'b0;
    logic [2:0] pkt_cnt_o;
    logic [7:0] drop_cnt_o;

    always #5 clk = ~clk;

    usb_rx_pkt_fifo dut (
        .clk_i(clk), .reset_i(reset_i), .rxdat_i(rxdat_i),
        .rxval_i(rxval_i), .rxact_i(rxact_i), .rxpktval_i(rxpktval_i),
        .setup_i(setup_i), .endpt_i(endpt_i), .rxrdy_o(rxrdy_o),
        .m_dat_o(m_dat_o), .m_val_o(m_val_o), .m_last_o(m_last_o),
        .m_rdy_i(m_rdy_i), .pkt_cnt_o(pkt_cnt_o), .drop_cnt_o(drop_cnt_o)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];
    logic [8:0] rx_q[$];
    int acc_lens[$];
    int rx_last_cnt = 0;
    int exp_drop = 0;
    int chk_idx = 0;
    bit rand_rdy = 0;

    // Record every accepted output byte with its last flag
    always @(negedge clk) begin
        if (!reset_i && m_val_o && m_rdy_i) begin
            rx_q.push_back({m_last_o, m_dat_o});
            if (m_last_o) rx_last_cnt++;
        end
    end

    function automatic int out_pkts();
        return acc_lens.size() - rx_last_cnt;
    endfunction

    function automatic int out_bytes();
        int s = 0;
        for (int k = rx_last_cnt; k < acc_lens.size(); k++) s += acc_lens[k];
        return s;
    endfunction

    function automatic bit exp_rdy();
        return (2048 - out_bytes() >= 512) && (out_pkts() < 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) m_rdy_i = 1'($urandom_range(0, 1));
    endtask

    task automatic send_pkt(input int ep, input bit setup, input int len,
                            input bit good, input bit wait_rdy);
        logic [7:0] b;
        bit tgt, accept, drop;
        int t;
        t = 0;
        if (wait_rdy)
            while (!rxrdy_o && t < 5000) begin tick(); t++; end
        tgt = (ep == 1) && !setup;
        accept = tgt && good && len > 0 && len <= 512;
        drop = tgt && (!good || len > 512);
        endpt_i = 4'(ep);
        setup_i = setup;
        rxact_i = 1'b1;
        tick();
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rxval_i = 1'b0;
                tick();
            end
            b = 8'($urandom);
            rxval_i = 1'b1;
            rxdat_i = b;
            if (accept) exp_q.push_back({i == len - 1, b});
            tick();
        end
        rxval_i = 1'b0;
        rxpktval_i = good;
        tick();
        rxpktval_i = 1'b0;
        rxact_i = 1'b0;
        tick();
        if (accept) acc_lens.push_back(len);
        if (drop && exp_drop < 255) exp_drop++;
    endtask

    task automatic drain();
        int t;
        t = 0;
        m_rdy_i = 1'b1;
        while (rx_q.size() < exp_q.size() && t < 6000) begin tick(); t++; end
        tick();
        tick();
        m_rdy_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) tick();
        n_chk += 6;
        if (m_val_o !== 1'b0) begin n_err++; $display("FAIL rst m_val: got %b want 0", m_val_o); end
        if (m_last_o !== 1'b0) begin n_err++; $display("FAIL rst m_last: got %b want 0", m_last_o); end
        if (m_dat_o !== 8'h00) begin n_err++; $display("FAIL rst m_dat: got %h want 00", m_dat_o); end
        if (rxrdy_o !== 1'b0) begin n_err++; $display("FAIL rst rxrdy: got %b want 0", rxrdy_o); end
        if (pkt_cnt_o !== 3'd0) begin n_err++; $display("FAIL rst pkt_cnt: got %0d want 0", pkt_cnt_o); end
        if (drop_cnt_o !== 8'd0) begin n_err++; $display("FAIL rst drop_cnt: got %0d want 0", drop_cnt_o); end
        reset_i = 1'b0;
        tick();
        n_chk++;
        if (rxrdy_o !== 1'b1) begin n_err++; $display("FAIL rst rxrdy_after: got %b want 1", rxrdy_o); end
    endtask

    task automatic test_good64();
        int t;
        logic [7:0] d0;
        logic l0;
        m_rdy_i = 1'b0;
        send_pkt(1, 0, 64, 1, 1);
        n_chk++;
        if (pkt_cnt_o !== 3'd1) begin n_err++; $display("FAIL g64 pkt_cnt: got %0d want 1", pkt_cnt_o); end
        t = 0;
        while (!m_val_o && t < 3) begin tick(); t++; end
        n_chk++;
        if (m_val_o !== 1'b1) begin n_err++; $display("FAIL g64 latency: m_val %b after %0d cycles want 1", m_val_o, t); end
        d0 = m_dat_o;
        l0 = m_last_o;
        n_chk++;
        if ({l0, d0} !== exp_q[chk_idx]) begin n_err++; $display("FAIL g64 first: got %h want %h", {l0, d0}, exp_q[chk_idx]); end
        repeat (4) begin
            tick();
            n_chk++;
            if (m_dat_o !== d0 || m_last_o !== l0 || m_val_o !== 1'b1)
                begin n_err++; $display("FAIL g64 stall: got %b/%h want 1/%h", m_val_o, m_dat_o, d0); end
        end
        drain();
        n_chk += 2;
        if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL g64 count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        if (pkt_cnt_o !== 3'd0) begin n_err++; $display("FAIL g64 pkt_cnt_end: got %0d want 0", pkt_cnt_o); end
        for (int i = chk_idx; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_chk++;
            if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL g64 data[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        chk_idx = exp_q.size();
    endtask

    task automatic test_no_good();
        send_pkt(1, 0, 64, 0, 1);
        repeat (4) tick();
        n_chk += 3;
        if (drop_cnt_o !== 8'(exp_drop)) begin n_err++; $display("FAIL nogood drop: got %0d want %0d", drop_cnt_o, exp_drop); end
        if (m_val_o !== 1'b0) begin n_err++; $display("FAIL nogood m_val: got %b want 0", m_val_o); end
        if (pkt_cnt_o !== 3'd0) begin n_err++; $display("FAIL nogood pkt_cnt: got %0d want 0", pkt_cnt_o); end
        send_pkt(1, 0, 8, 1, 1);
        drain();
        n_chk++;
        if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL nogood count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = chk_idx; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_chk++;
            if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL nogood data[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        chk_idx = exp_q.size();
    endtask

    task automatic test_filtered();
        send_pkt(1, 1, 16, 1, 1);
        send_pkt(2, 0, 16, 1, 1);
        send_pkt(1, 0, 0, 1, 1);
        repeat (4) tick();
        n_chk += 4;
        if (drop_cnt_o !== 8'(exp_drop)) begin n_err++; $display("FAIL filt drop: got %0d want %0d", drop_cnt_o, exp_drop); end
        if (m_val_o !== 1'b0) begin n_err++; $display("FAIL filt m_val: got %b want 0", m_val_o); end
        if (pkt_cnt_o !== 3'd0) begin n_err++; $display("FAIL filt pkt_cnt: got %0d want 0", pkt_cnt_o); end
        if (rxrdy_o !== 1'b1) begin n_err++; $display("FAIL filt rxrdy: got %b want 1", rxrdy_o); end
    endtask

    task automatic test_oversize();
        send_pkt(1, 0, 600, 1, 1);
        tick();
        n_chk += 3;
        if (drop_cnt_o !== 8'(exp_drop)) begin n_err++; $display("FAIL ovr drop: got %0d want %0d", drop_cnt_o, exp_drop); end
        if (rxrdy_o !== 1'b1) begin n_err++; $display("FAIL ovr rxrdy: got %b want 1", rxrdy_o); end
        if (pkt_cnt_o !== 3'd0) begin n_err++; $display("FAIL ovr pkt_cnt: got %0d want 0", pkt_cnt_o); end
        send_pkt(1, 0, 512, 1, 1);
        drain();
        n_chk++;
        if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL max count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = chk_idx; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_chk++;
            if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL max data[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        chk_idx = exp_q.size();
    endtask

    task automatic test_fill();
        m_rdy_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_pkt(1, 0, 512, 1, 1);
            n_chk += 2;
            if (rxrdy_o !== exp_rdy()) begin n_err++; $display("FAIL fill rxrdy[%0d]: got %b want %b", k, rxrdy_o, exp_rdy()); end
            if (pkt_cnt_o !== 3'(out_pkts())) begin n_err++; $display("FAIL fill pkt_cnt[%0d]: got %0d want %0d", k, pkt_cnt_o, out_pkts()); end
        end
        drain();
        n_chk++;
        if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL fill count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = chk_idx; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_chk++;
            if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL fill data[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        chk_idx = exp_q.size();
    endtask

    task automatic test_lq_full();
        int t;
        int base;
        m_rdy_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_pkt(1, 0, $urandom_range(2, 20), 1, 1);
            n_chk++;
            if (rxrdy_o !== exp_rdy()) begin n_err++; $display("FAIL lq rxrdy[%0d]: got %b want %b", k, rxrdy_o, exp_rdy()); end
        end
        base = rx_last_cnt;
        t = 0;
        m_rdy_i = 1'b1;
        while (rx_last_cnt == base && t < 100) begin tick(); t++; end
        m_rdy_i = 1'b0;
        tick();
        n_chk += 2;
        if (rxrdy_o !== exp_rdy()) begin n_err++; $display("FAIL lq rxrdy_pop: got %b want %b", rxrdy_o, exp_rdy()); end
        if (pkt_cnt_o !== 3'(out_pkts())) begin n_err++; $display("FAIL lq pkt_cnt: got %0d want %0d", pkt_cnt_o, out_pkts()); end
        drain();
        n_chk++;
        if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL lq count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = chk_idx; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_chk++;
            if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL lq data[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        chk_idx = exp_q.size();
    endtask

    task automatic test_back_to_back();
        int total, got, bubbles, t;
        m_rdy_i = 1'b0;
        total = 0;
        for (int k = 0; k < 3; k++) begin
            int len = $urandom_range(5, 40);
            send_pkt(1, 0, len, 1, 1);
            total += len;
        end
        repeat (3) tick();
        m_rdy_i = 1'b1;
        got = 0;
        bubbles = 0;
        t = 0;
        while (got < total && t < 500) begin
            @(negedge clk);
            if (m_val_o) got++;
            else bubbles++;
            t++;
        end
        @(posedge clk);
        #1;
        m_rdy_i = 1'b0;
        tick();
        n_chk += 3;
        if (bubbles != 0) begin n_err++; $display("FAIL b2b bubbles: got %0d want 0", bubbles); end
        if (got != total) begin n_err++; $display("FAIL b2b bytes: got %0d want %0d", got, total); end
        if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = chk_idx; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_chk++;
            if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b data[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        chk_idx = exp_q.size();
    endtask

    task automatic test_random();
        rand_rdy = 1;
        for (int k = 0; k < 25; k++) begin
            int ep, len;
            bit su, gd;
            ep = ($urandom_range(0, 9) == 0) ? 3 : 1;
            su = ($urandom_range(0, 9) == 0);
            gd = ($urandom_range(0, 4) != 0);
            len = $urandom_range(0, 100);
            if ($urandom_range(0, 19) == 0) len = 520;
            send_pkt(ep, su, len, gd, 1);
        end
        rand_rdy = 0;
        drain();
        n_chk += 3;
        if (drop_cnt_o !== 8'(exp_drop)) begin n_err++; $display("FAIL rnd drop: got %0d want %0d", drop_cnt_o, exp_drop); end
        if (pkt_cnt_o !== 3'd0) begin n_err++; $display("FAIL rnd pkt_cnt: got %0d want 0", pkt_cnt_o); end
        if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL rnd count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = chk_idx; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_chk++;
            if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd data[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        chk_idx = exp_q.size();
    endtask

    task automatic test_mid_reset();
        m_rdy_i = 1'b0;
        send_pkt(1, 0, 20, 1, 1);
        send_pkt(1, 0, 30, 1, 1);
        endpt_i = 4'd1;
        setup_i = 1'b0;
        rxact_i = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            rxval_i = 1'b1;
            rxdat_i = 8'($urandom);
            tick();
        end
        reset_i = 1'b1;
        rxval_i = 1'b0;
        rxact_i = 1'b0;
        tick();
        while (exp_q.size() > rx_q.size()) void'(exp_q.pop_back());
        while (acc_lens.size() > rx_last_cnt) void'(acc_lens.pop_back());
        exp_drop = 0;
        n_chk += 4;
        if (m_val_o !== 1'b0) begin n_err++; $display("FAIL mrst m_val: got %b want 0", m_val_o); end
        if (pkt_cnt_o !== 3'd0) begin n_err++; $display("FAIL mrst pkt_cnt: got %0d want 0", pkt_cnt_o); end
        if (drop_cnt_o !== 8'd0) begin n_err++; $display("FAIL mrst drop: got %0d want 0", drop_cnt_o); end
        if (rxrdy_o !== 1'b0) begin n_err++; $display("FAIL mrst rxrdy: got %b want 0", rxrdy_o); end
        reset_i = 1'b0;
        tick();
        n_chk++;
        if (rxrdy_o !== 1'b1) begin n_err++; $display("FAIL mrst rxrdy_after: got %b want 1", rxrdy_o); end
        send_pkt(1, 0, 12, 1, 1);
        drain();
        n_chk++;
        if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL mrst count: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = chk_idx; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_chk++;
            if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL mrst data[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        chk_idx = exp_q.size();
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 260; k++) send_pkt(1, 0, 1, 0, 0);
        tick();
        n_chk++;
        if (drop_cnt_o !== 8'(exp_drop)) begin n_err++; $display("FAIL sat drop: got %0d want %0d", drop_cnt_o, exp_drop); end
    endtask

    initial begin
        test_reset();
        test_good64();
        test_no_good();
        test_filtered();
        test_oversize();
        test_fill();
        test_lq_full();
        test_back_to_back();
        test_random();
        test_mid_reset();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
